// File: rtl/v_lane_writeback.sv
// Vector lane writeback: snapshots ALU/MUL result groups on completion edges and
// streams them into the VRF one 128-bit register per cycle, with ALU priority.
module v_lane_writeback #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_valu,
  input  logic              done_vmul,
  input  logic [DATA_W-1:0] result_valu_1,
  input  logic [DATA_W-1:0] result_valu_2,
  input  logic [DATA_W-1:0] result_valu_3,
  input  logic [DATA_W-1:0] result_valu_4,
  input  logic [DATA_W-1:0] result_vmul_1,
  input  logic [DATA_W-1:0] result_vmul_2,
  input  logic [DATA_W-1:0] result_vmul_3,
  input  logic [DATA_W-1:0] result_vmul_4,
  input  logic [2:0]        lmul,
  input  logic [4:0]        vd,
  output logic              vrf_we,
  output logic [4:0]        vrf_waddr,
  output logic [DATA_W-1:0] vrf_wdata,
  output logic              busy,
  output logic              wb_done,
  output logic              ovf_err
);

  typedef enum logic [1:0] {S_IDLE, S_WB_ALU, S_WB_MUL} state_t;

  state_t            r_state;
  logic [1:0]        r_k;
  logic              r_prev_valu;
  logic              r_prev_vmul;
  logic              r_alu_pend;
  logic              r_mul_pend;
  logic              r_ovf;
  logic [DATA_W-1:0] r_alu_data [4];
  logic [DATA_W-1:0] r_mul_data [4];
  logic [4:0]        r_alu_vd;
  logic [4:0]        r_mul_vd;
  logic [1:0]        r_alu_last;
  logic [1:0]        r_mul_last;

  logic              w_ev_alu;
  logic              w_ev_mul;
  logic              w_cap_alu;
  logic              w_cap_mul;

  // Group size is stored as the index of the final beat so k compares directly.
  function automatic logic [1:0] last_beat(input logic [2:0] m);
    case (m)
      3'b001:  last_beat = 2'd1;
      3'b010:  last_beat = 2'd3;
      default: last_beat = 2'd0;
    endcase
  endfunction

  assign w_ev_alu  = done_valu & ~r_prev_valu;
  assign w_ev_mul  = done_vmul & ~r_prev_vmul;
  assign w_cap_alu = w_ev_alu & ~r_alu_pend & ~rst;
  assign w_cap_mul = w_ev_mul & ~r_mul_pend & ~rst;

  // Slot payload: loaded only on an accepted capture, never reset.
  always_ff @(posedge clk) begin
    if (w_cap_alu) begin
      r_alu_data[0] <= result_valu_1;
      r_alu_data[1] <= result_valu_2;
      r_alu_data[2] <= result_valu_3;
      r_alu_data[3] <= result_valu_4;
      r_alu_vd      <= vd;
      r_alu_last    <= last_beat(lmul);
    end
    if (w_cap_mul) begin
      r_mul_data[0] <= result_vmul_1;
      r_mul_data[1] <= result_vmul_2;
      r_mul_data[2] <= result_vmul_3;
      r_mul_data[3] <= result_vmul_4;
      r_mul_vd      <= vd;
      r_mul_last    <= last_beat(lmul);
    end
  end

  // Control: edge detect, pend flags, overrun flag and writeback FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= 2'd0;
      r_prev_valu <= 1'b0;
      r_prev_vmul <= 1'b0;
      r_alu_pend  <= 1'b0;
      r_mul_pend  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_prev_valu <= done_valu;
      r_prev_vmul <= done_vmul;
      // Set and clear of a pend flag are mutually exclusive: set needs pend=0.
      if (w_ev_alu) begin
        if (r_alu_pend) r_ovf <= 1'b1;
        else            r_alu_pend <= 1'b1;
      end
      if (w_ev_mul) begin
        if (r_mul_pend) r_ovf <= 1'b1;
        else            r_mul_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_k <= 2'd0;
          if (r_alu_pend)      r_state <= S_WB_ALU;
          else if (r_mul_pend) r_state <= S_WB_MUL;
        end
        S_WB_ALU: begin
          if (r_k == r_alu_last) begin
            r_alu_pend <= 1'b0;
            r_k        <= 2'd0;
            r_state    <= r_mul_pend ? S_WB_MUL : S_IDLE;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        S_WB_MUL: begin
          if (r_k == r_mul_last) begin
            r_mul_pend <= 1'b0;
            r_k        <= 2'd0;
            r_state    <= S_IDLE;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_k     <= 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    vrf_we    = 1'b0;
    vrf_waddr = 5'd0;
    vrf_wdata = '0;
    wb_done   = 1'b0;
    case (r_state)
      S_WB_ALU: begin
        vrf_we    = 1'b1;
        vrf_waddr = r_alu_vd + {3'b000, r_k};
        vrf_wdata = r_alu_data[r_k];
        wb_done   = (r_k == r_alu_last);
      end
      S_WB_MUL: begin
        vrf_we    = 1'b1;
        vrf_waddr = r_mul_vd + {3'b000, r_k};
        vrf_wdata = r_mul_data[r_k];
        wb_done   = (r_k == r_mul_last);
      end
      default: ;
    endcase
  end

  assign busy    = r_alu_pend | r_mul_pend;
  assign ovf_err = r_ovf;

endmodule

// File: tb/tb_v_lane_writeback.sv
// Directed bench for v_lane_writeback: single groups, wrap-around, dual events,
// overrun drop and mid-group reset, each against hand-computed write sequences.
module tb_v_lane_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         done_valu, done_vmul;
  logic [127:0] result_valu_1, result_valu_2, result_valu_3, result_valu_4;
  logic [127:0] result_vmul_1, result_vmul_2, result_vmul_3, result_vmul_4;
  logic [2:0]   lmul;
  logic [4:0]   vd;
  logic         vrf_we;
  logic [4:0]   vrf_waddr;
  logic [127:0] vrf_wdata;
  logic         busy, wb_done, ovf_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] A1 = {4{32'hA1A1_0001}};
  localparam logic [127:0] A2 = {4{32'hA2A2_0002}};
  localparam logic [127:0] A3 = {4{32'hA3A3_0003}};
  localparam logic [127:0] A4 = {4{32'hA4A4_0004}};
  localparam logic [127:0] M1 = {4{32'h5151_1111}};
  localparam logic [127:0] M2 = {4{32'h5252_2222}};
  localparam logic [127:0] M3 = {4{32'h5353_3333}};
  localparam logic [127:0] M4 = {4{32'h5454_4444}};
  localparam logic [127:0] BAD = {4{32'hDEAD_BEEF}};

  v_lane_writeback dut (
    .clk(clk), .rst(rst), .done_valu(done_valu), .done_vmul(done_vmul),
    .result_valu_1(result_valu_1), .result_valu_2(result_valu_2),
    .result_valu_3(result_valu_3), .result_valu_4(result_valu_4),
    .result_vmul_1(result_vmul_1), .result_vmul_2(result_vmul_2),
    .result_vmul_3(result_vmul_3), .result_vmul_4(result_vmul_4),
    .lmul(lmul), .vd(vd), .vrf_we(vrf_we), .vrf_waddr(vrf_waddr),
    .vrf_wdata(vrf_wdata), .busy(busy), .wb_done(wb_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_write(input string tag, input logic [4:0] a, input logic [127:0] d,
                           input logic dn);
    chk({tag, ".we"},    {127'd0, vrf_we},  128'd1);
    chk({tag, ".addr"},  {123'd0, vrf_waddr}, {123'd0, a});
    chk({tag, ".data"},  vrf_wdata, d);
    chk({tag, ".done"},  {127'd0, wb_done}, {127'd0, dn});
  endtask

  task automatic exp_idle(input string tag, input logic bsy);
    chk({tag, ".we"},    {127'd0, vrf_we},  128'd0);
    chk({tag, ".addr"},  {123'd0, vrf_waddr}, 128'd0);
    chk({tag, ".data"},  vrf_wdata, 128'd0);
    chk({tag, ".done"},  {127'd0, wb_done}, 128'd0);
    chk({tag, ".busy"},  {127'd0, busy},    {127'd0, bsy});
  endtask

  initial begin
    rst = 1'b1; done_valu = 1'b0; done_vmul = 1'b0; lmul = 3'b000; vd = 5'd0;
    result_valu_1 = '0; result_valu_2 = '0; result_valu_3 = '0; result_valu_4 = '0;
    result_vmul_1 = '0; result_vmul_2 = '0; result_vmul_3 = '0; result_vmul_4 = '0;
    tick(); tick();
    exp_idle("reset", 1'b0);
    chk("reset.ovf", {127'd0, ovf_err}, 128'd0);
    rst = 1'b0;
    tick();

    // Single ALU register, lmul=000, vd=5
    lmul = 3'b000; vd = 5'd5; result_valu_1 = A1; done_valu = 1'b1;
    tick();
    exp_idle("t1.cap", 1'b1);
    done_valu = 1'b0;
    tick();
    exp_write("t1.w0", 5'd5, A1, 1'b1);
    tick();
    exp_idle("t1.end", 1'b0);

    // MUL group of 4 wrapping past 31; inputs changed after capture
    lmul = 3'b010; vd = 5'd30;
    result_vmul_1 = M1; result_vmul_2 = M2; result_vmul_3 = M3; result_vmul_4 = M4;
    done_vmul = 1'b1;
    tick();
    done_vmul = 1'b0; lmul = 3'b000; vd = 5'd9;
    result_vmul_1 = BAD; result_vmul_2 = BAD; result_vmul_3 = BAD; result_vmul_4 = BAD;
    tick(); exp_write("t2.w0", 5'd30, M1, 1'b0);
    tick(); exp_write("t2.w1", 5'd31, M2, 1'b0);
    tick(); exp_write("t2.w2", 5'd0,  M3, 1'b0);
    tick(); exp_write("t2.w3", 5'd1,  M4, 1'b1);
    tick(); exp_idle("t2.end", 1'b0);

    // Simultaneous ALU and MUL events, lmul=001, vd=2
    lmul = 3'b001; vd = 5'd2;
    result_valu_1 = A1; result_valu_2 = A2; result_vmul_1 = M1; result_vmul_2 = M2;
    done_valu = 1'b1; done_vmul = 1'b1;
    tick();
    done_valu = 1'b0; done_vmul = 1'b0;
    tick(); exp_write("t3.a0", 5'd2, A1, 1'b0);
    tick(); exp_write("t3.a1", 5'd3, A2, 1'b1);
    tick(); exp_write("t3.m0", 5'd2, M1, 1'b0);
    tick(); exp_write("t3.m1", 5'd3, M2, 1'b1);
    tick(); exp_idle("t3.end", 1'b0);

    // Second ALU event during a 4-beat ALU writeback is dropped
    lmul = 3'b010; vd = 5'd10;
    result_valu_1 = A1; result_valu_2 = A2; result_valu_3 = A3; result_valu_4 = A4;
    done_valu = 1'b1;
    tick();
    done_valu = 1'b0;
    tick(); exp_write("t4.w0", 5'd10, A1, 1'b0);
    chk("t4.ovf0", {127'd0, ovf_err}, 128'd0);
    result_valu_1 = BAD; result_valu_2 = BAD; result_valu_3 = BAD; result_valu_4 = BAD;
    vd = 5'd20; done_valu = 1'b1;
    tick(); exp_write("t4.w1", 5'd11, A2, 1'b0);
    chk("t4.ovf1", {127'd0, ovf_err}, 128'd1);
    done_valu = 1'b0;
    tick(); exp_write("t4.w2", 5'd12, A3, 1'b0);
    tick(); exp_write("t4.w3", 5'd13, A4, 1'b1);
    tick(); exp_idle("t4.end", 1'b0);
    chk("t4.ovf_hold", {127'd0, ovf_err}, 128'd1);

    // Reset after beat 2 of a 4-beat MUL group; done held high across reset
    lmul = 3'b010; vd = 5'd20;
    result_vmul_1 = M1; result_vmul_2 = M2; result_vmul_3 = M3; result_vmul_4 = M4;
    done_vmul = 1'b1;
    tick();
    tick(); exp_write("t5.w0", 5'd20, M1, 1'b0);
    tick(); exp_write("t5.w1", 5'd21, M2, 1'b0);
    rst = 1'b1;
    tick(); exp_idle("t5.rst", 1'b0);
    chk("t5.ovf", {127'd0, ovf_err}, 128'd0);
    rst = 1'b0;
    tick();
    exp_idle("t5.recap", 1'b1);
    done_vmul = 1'b0;
    tick(); exp_write("t5.r0", 5'd20, M1, 1'b0);
    tick(); exp_write("t5.r1", 5'd21, M2, 1'b0);
    tick(); exp_write("t5.r2", 5'd22, M3, 1'b0);
    tick(); exp_write("t5.r3", 5'd23, M4, 1'b1);
    tick(); exp_idle("t5.end", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
